// File: rtl/jb_obs_path_pkg.sv
// rtl/jb_obs_path_pkg.sv - shared encodings for the observation-path scheduler
//
// Purpose: request-type codes, tdata field positions and FSM state codes
//          shared by jb_obs_path_sched and its bench.
// Ports:   none (package).

package jb_obs_path_pkg;

    // Request tdata layout: [7:4] type, [3] reserved, [2:0] antenna.
    localparam int REQ_TYPE_MSB = 7;
    localparam int REQ_TYPE_LSB = 4;
    localparam int REQ_ANT_MSB  = 2;
    localparam int REQ_ANT_LSB  = 0;

    localparam logic [3:0] REQ_DPD   = 4'h0;
    localparam logic [3:0] REQ_HIRES = 4'h1;
    localparam logic [3:0] REQ_VSWR  = 4'h2;
    localparam logic [3:0] REQ_AVAIL = 4'hF;

    typedef logic [2:0] state_t;

    localparam state_t ST_PASS    = 3'd0;
    localparam state_t ST_PICK    = 3'd1;
    localparam state_t ST_VREQ    = 3'd2;
    localparam state_t ST_SETTLE  = 3'd3;
    localparam state_t ST_DWELL   = 3'd4;
    localparam state_t ST_RESTORE = 3'd5;

    function automatic logic [3:0] req_type(input logic [7:0] tdata);
        return tdata[REQ_TYPE_MSB:REQ_TYPE_LSB];
    endfunction

    function automatic logic [7:0] vswr_beat(input logic [2:0] ant);
        logic [7:0] beat;
        beat = '0;
        beat[REQ_TYPE_MSB:REQ_TYPE_LSB] = REQ_VSWR;
        beat[REQ_ANT_MSB:REQ_ANT_LSB]   = ant;
        return beat;
    endfunction

    // Only real path configurations are worth restoring; AVAIL is a hint.
    function automatic logic is_path_cfg(input logic [3:0] t);
        return (t == REQ_DPD) || (t == REQ_HIRES) || (t == REQ_VSWR);
    endfunction

endpackage

// File: rtl/jb_rr_mask_pick.sv
// rtl/jb_rr_mask_pick.sv - round-robin next-set-bit picker with wrap
//
// Purpose: returns the first set bit of mask strictly after ptr, wrapping
//          modulo N_ANTENNAS; ptr itself is the last candidate.
// Ports:   mask - candidate bits; ptr - last served index;
//          next - chosen index (ptr when mask is empty); any - mask nonzero.

module jb_rr_mask_pick #(
    parameter int N_ANTENNAS = 4
) (
    input  logic [N_ANTENNAS-1:0] mask,
    input  logic [2:0]            ptr,
    output logic [2:0]            next,
    output logic                  any
);

    int best_off;
    int off;

    always_comb begin
        next     = ptr;
        any      = |mask;
        best_off = N_ANTENNAS;
        off      = 0;
        for (int j = 0; j < N_ANTENNAS; j++) begin
            // Distance from ptr+1 to j going upward with wrap; the 8*N bias
            // keeps the dividend non-negative for any 3-bit ptr.
            off = (j + 8 * N_ANTENNAS - 1 - int'(ptr)) % N_ANTENNAS;
            if (mask[j] && (off < best_off)) begin
                best_off = off;
                next     = 3'(j);
            end
        end
    end

endmodule

// File: rtl/jb_obs_path_sched.sv
// rtl/jb_obs_path_sched.sv - shares the SRX/ORX path between DPD and VSWR scans
//
// Purpose: merges DPD srx_ctrl requests with background VSWR measurement
//          requests; DPD always wins and preempts an open VSWR window.
// Ports:   axis_aclk/axis_areset - clock, sync active-high reset
//          vswr_en, ant_mask, dwell_cycles, idle_timeout - scan config
//          dpd_req_* - DPD request stream in; srx_req_* - merged stream out
//          srx_grant - antenna switch settled pulse
//          meas_active/meas_ant/meas_done/meas_abort - detector window
//          vswr_owner - VSWR currently owns the path

module jb_obs_path_sched
    import jb_obs_path_pkg::*;
#(
    parameter int N_ANTENNAS = 4,
    parameter int DWELL_W    = 16
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    input  logic                  vswr_en,
    input  logic [N_ANTENNAS-1:0] ant_mask,
    input  logic [DWELL_W-1:0]    dwell_cycles,
    input  logic [DWELL_W-1:0]    idle_timeout,
    input  logic                  dpd_req_tvalid,
    input  logic [7:0]            dpd_req_tdata,
    output logic                  dpd_req_tready,
    output logic                  srx_req_tvalid,
    output logic [7:0]            srx_req_tdata,
    input  logic                  srx_req_tready,
    input  logic                  srx_grant,
    output logic                  meas_active,
    output logic [2:0]            meas_ant,
    output logic                  meas_done,
    output logic                  meas_abort,
    output logic                  vswr_owner
);

    state_t               state_q, state_d;
    logic [2:0]           meas_ant_q, meas_ant_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [7:0]           last_dpd_req_q, last_dpd_req_d;
    logic [DWELL_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;

    logic [2:0]           pick_next;
    logic                 pick_any;
    logic [3:0]           dpd_type;
    logic                 dpd_preempt;
    logic                 scan_ok;
    logic [DWELL_W-1:0]   dwell_last;

    jb_rr_mask_pick #(.N_ANTENNAS(N_ANTENNAS)) u_pick (
        .mask (ant_mask),
        .ptr  (rr_ptr_q),
        .next (pick_next),
        .any  (pick_any)
    );

    assign dpd_type    = req_type(dpd_req_tdata);
    assign dpd_preempt = dpd_req_tvalid && (dpd_type != REQ_AVAIL);
    assign scan_ok     = vswr_en && (|ant_mask);
    // A zero dwell still opens a one-cycle window.
    assign dwell_last  = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_W'(1);

    assign meas_active = (state_q == ST_DWELL);
    assign meas_ant    = meas_ant_q;
    assign vswr_owner  = (state_q != ST_PASS);

    always_comb begin
        state_d        = state_q;
        meas_ant_d     = meas_ant_q;
        rr_ptr_d       = rr_ptr_q;
        last_dpd_req_d = last_dpd_req_q;
        idle_cnt_d     = '0;   // the idle counter only runs while DPD owns the path
        dwell_cnt_d    = dwell_cnt_q;
        srx_req_tvalid = 1'b0;
        srx_req_tdata  = '0;
        dpd_req_tready = 1'b0;
        meas_done      = 1'b0;
        meas_abort     = 1'b0;

        case (state_q)
            ST_PASS: begin
                srx_req_tvalid = dpd_req_tvalid;
                srx_req_tdata  = dpd_req_tdata;
                dpd_req_tready = srx_req_tready;
                if (dpd_req_tvalid && srx_req_tready) begin
                    idle_cnt_d = '0;
                    if (is_path_cfg(dpd_type)) begin
                        last_dpd_req_d = dpd_req_tdata;
                    end
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + DWELL_W'(1);
                end else begin
                    idle_cnt_d = idle_cnt_q;
                end
                if (scan_ok &&
                    ((dpd_req_tvalid && srx_req_tready && (dpd_type == REQ_AVAIL)) ||
                     ((idle_timeout != '0) && (idle_cnt_q == idle_timeout)))) begin
                    state_d = ST_PICK;
                end
            end
            ST_PICK: begin
                if (!vswr_en || !pick_any) begin
                    state_d = ST_RESTORE;
                end else begin
                    meas_ant_d = pick_next;
                    state_d    = ST_VREQ;
                end
            end
            ST_VREQ: begin
                // DPD stays blocked so its beat waits rather than being lost.
                srx_req_tvalid = 1'b1;
                srx_req_tdata  = vswr_beat(meas_ant_q);
                if (srx_req_tready) begin
                    state_d = vswr_en ? ST_SETTLE : ST_RESTORE;
                end
            end
            ST_SETTLE: begin
                dpd_req_tready = (dpd_type == REQ_AVAIL);   // AVAIL is swallowed
                if (dpd_preempt) begin
                    meas_abort = 1'b1;
                    state_d    = ST_PASS;
                end else if (!vswr_en) begin
                    state_d = ST_RESTORE;
                end else if (srx_grant) begin
                    dwell_cnt_d = '0;
                    state_d     = ST_DWELL;
                end
            end
            ST_DWELL: begin
                dpd_req_tready = (dpd_type == REQ_AVAIL);
                if (dpd_preempt) begin
                    // rr_ptr stays put so this antenna leads the next scan.
                    meas_abort = 1'b1;
                    state_d    = ST_PASS;
                end else if (!vswr_en) begin
                    meas_abort = 1'b1;
                    state_d    = ST_RESTORE;
                end else if (dwell_cnt_q == dwell_last) begin
                    meas_done = 1'b1;
                    rr_ptr_d  = meas_ant_q;
                    state_d   = ST_PICK;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end
            ST_RESTORE: begin
                // Put the switches back where DPD last left them.
                srx_req_tvalid = 1'b1;
                srx_req_tdata  = last_dpd_req_q;
                if (srx_req_tready) begin
                    state_d = ST_PASS;
                end
            end
            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_q        <= ST_PASS;
            meas_ant_q     <= '0;
            rr_ptr_q       <= 3'(N_ANTENNAS - 1);
            last_dpd_req_q <= 8'h00;
            idle_cnt_q     <= '0;
            dwell_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            meas_ant_q     <= meas_ant_d;
            rr_ptr_q       <= rr_ptr_d;
            last_dpd_req_q <= last_dpd_req_d;
            idle_cnt_q     <= idle_cnt_d;
            dwell_cnt_q    <= dwell_cnt_d;
        end
    end

endmodule
